rs_issue_scheduler: RTL and testbench

Controller for the Tomasulo add/sub reservation station. It allocates dispatched instructions into NUM_ENTRIES station slots and snoops the common data bus (CDB) to wake pending operands. Each cycle it selects the oldest entry with both operands ready and issues it to the adder functional unit over a valid/ready handshake. It sits between the dispatch logic and the adder FU, and owns station occupancy and free-slot bookkeeping.

---
 rtl/rs_issue_scheduler.sv | 170 +++++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// Tomasulo add/sub reservation station: allocates into free slots, wakes operands from the CDB, issues oldest-ready.
// Issue register loads one edge after a slot is ready and holds while !iss_ready; `RS_STALL_CNT_EN adds stall counters.
module rs_issue_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int DATA_W      = 16,
  parameter int TAG_W       = 3,
  parameter int FUNC_W      = 5
) (
  input  logic                           clk1,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [FUNC_W-1:0]              disp_func,
  input  logic [TAG_W-1:0]               disp_rob,
  input  logic [DATA_W-1:0]              disp_v1,
  input  logic [DATA_W-1:0]              disp_v2,
  input  logic [TAG_W-1:0]               disp_q1,
  input  logic [TAG_W-1:0]               disp_q2,
  input  logic                           disp_p1,
  input  logic                           disp_p2,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [FUNC_W-1:0]              iss_func,
  output logic [TAG_W-1:0]               iss_rob,
  output logic [DATA_W-1:0]              iss_op1,
  output logic [DATA_W-1:0]              iss_op2,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy
`ifdef RS_STALL_CNT_EN
  ,
  output logic [15:0]                    stall_disp_cnt,
  output logic [15:0]                    stall_iss_cnt
`endif
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

  logic [NUM_ENTRIES-1:0] valid, p1, p2, rdy, sel, valid_nxt;
  logic [FUNC_W-1:0]      func [NUM_ENTRIES];
  logic [TAG_W-1:0]       rob  [NUM_ENTRIES];
  logic [TAG_W-1:0]       q1   [NUM_ENTRIES];
  logic [TAG_W-1:0]       q2   [NUM_ENTRIES];
  logic [DATA_W-1:0]      v1   [NUM_ENTRIES];
  logic [DATA_W-1:0]      v2   [NUM_ENTRIES];
  // age[i][j] set means slot i was allocated before slot j
  logic [NUM_ENTRIES-1:0] age  [NUM_ENTRIES];
  logic [IDX_W-1:0]       free_idx, sel_idx;
  logic                   disp_fire, iss_fire, cap1, cap2;

  assign rdy       = valid & ~p1 & ~p2;
  assign disp_fire = disp_valid & disp_ready;
  assign iss_fire  = (~iss_valid | iss_ready) & (|rdy);
  assign cap1      = cdb_valid & disp_p1 & (disp_q1 == cdb_tag);
  assign cap2      = cdb_valid & disp_p2 & (disp_q2 == cdb_tag);

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

  // A ready slot wins only if it is older than every other ready slot.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (rdy[i] && (&(age[i] | ~rdy | (NUM_ENTRIES'(1) << i)))) begin
        sel[i]  = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    valid_nxt = valid;
    if (iss_fire)  valid_nxt = valid_nxt & ~sel;
    if (disp_fire) valid_nxt[free_idx] = 1'b1;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      occupancy = occupancy + OCC_W'(valid[i]);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= '0;
      p1         <= '0;
      p2         <= '0;
      disp_ready <= 1'b0;
      iss_valid  <= 1'b0;
      iss_func   <= '0;
      iss_rob    <= '0;
      iss_op1    <= '0;
      iss_op2    <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        func[i] <= '0;
        rob[i]  <= '0;
        q1[i]   <= '0;
        q2[i]   <= '0;
        v1[i]   <= '0;
        v2[i]   <= '0;
        age[i]  <= '0;
      end
    end else if (flush) begin
      valid      <= '0;
      disp_ready <= 1'b1;
      iss_valid  <= 1'b0;
    end else begin
      valid      <= valid_nxt;
      disp_ready <= ~(&valid_nxt);
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (valid[i] && cdb_valid) begin
          if (p1[i] && q1[i] == cdb_tag) begin
            v1[i] <= cdb_data;
            p1[i] <= 1'b0;
          end
          if (p2[i] && q2[i] == cdb_tag) begin
            v2[i] <= cdb_data;
            p2[i] <= 1'b0;
          end
        end
      end
      if (disp_fire) begin
        func[free_idx] <= disp_func;
        rob[free_idx]  <= disp_rob;
        q1[free_idx]   <= disp_q1;
        q2[free_idx]   <= disp_q2;
        v1[free_idx]   <= cap1 ? cdb_data : disp_v1;
        v2[free_idx]   <= cap2 ? cdb_data : disp_v2;
        p1[free_idx]   <= disp_p1 & ~cap1;
        p2[free_idx]   <= disp_p2 & ~cap2;
        age[free_idx]  <= '0;
        for (int j = 0; j < NUM_ENTRIES; j++)
          age[j][free_idx] <= valid[j];
      end
      if (iss_fire) begin
        iss_valid <= 1'b1;
        iss_func  <= func[sel_idx];
        iss_rob   <= rob[sel_idx];
        iss_op1   <= v1[sel_idx];
        iss_op2   <= v2[sel_idx];
      end else if (iss_ready) begin
        iss_valid <= 1'b0;
      end
    end
  end

`ifdef RS_STALL_CNT_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stall_disp_cnt <= '0;
      stall_iss_cnt  <= '0;
    end else if (flush) begin
      stall_disp_cnt <= '0;
      stall_iss_cnt  <= '0;
    end else begin
      if (disp_valid && !disp_ready && stall_disp_cnt != 16'hFFFF)
        stall_disp_cnt <= stall_disp_cnt + 16'd1;
      if (iss_valid && !iss_ready && stall_iss_cnt != 16'hFFFF)
        stall_iss_cnt <= stall_iss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler; issued instructions are checked in order against a scoreboard queue.
module tb_rs_issue_scheduler;
  logic        clk1 = 1'b0;
  logic        rst_n, flush, disp_valid, disp_ready;
  logic [4:0]  disp_func;
  logic [2:0]  disp_rob, disp_q1, disp_q2, cdb_tag, iss_rob;
  logic [15:0] disp_v1, disp_v2, cdb_data, iss_op1, iss_op2;
  logic        disp_p1, disp_p2, cdb_valid, iss_valid, iss_ready;
  logic [4:0]  iss_func;
  logic [2:0]  occupancy;
`ifdef RS_STALL_CNT_EN
  logic [15:0] stall_disp_cnt, stall_iss_cnt;
`endif

  typedef struct {int func; int rob; int op1; int op2;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, n_pushed = 0, n_popped = 0;

  rs_issue_scheduler #(.NUM_ENTRIES(4), .DATA_W(16), .TAG_W(3), .FUNC_W(5)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_func(disp_func), .disp_rob(disp_rob),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_p1(disp_p1), .disp_p2(disp_p2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func), .iss_rob(iss_rob),
    .iss_op1(iss_op1), .iss_op2(iss_op2), .occupancy(occupancy)
`ifdef RS_STALL_CNT_EN
    , .stall_disp_cnt(stall_disp_cnt), .stall_iss_cnt(stall_iss_cnt)
`endif
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic expect_iss(input int f, input int r, input int a, input int b);
    sb.push_back('{f, r, a, b});
    n_pushed++;
  endtask

  task automatic disp(input int f, input int r, input int a, input int b,
                      input int pa, input int qa, input int pb, input int qb);
    disp_valid = 1'b1;
    disp_func  = 5'(f);
    disp_rob   = 3'(r);
    disp_v1    = 16'(a);
    disp_v2    = 16'(b);
    disp_p1    = 1'(pa);
    disp_q1    = 3'(qa);
    disp_p2    = 1'(pb);
    disp_q2    = 3'(qb);
  endtask

  task automatic cdb(input int t, input int d);
    cdb_valid = 1'b1;
    cdb_tag   = 3'(t);
    cdb_data  = 16'(d);
  endtask

  // Handshake monitor: every accepted issue must match the oldest expected entry.
  always @(negedge clk1) begin
    if (rst_n && !flush && iss_valid && iss_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_issue: observed rob %0h expected no issue", iss_rob);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        n_popped++;
        chk("sb_func", 32'(iss_func), e.func);
        chk("sb_rob",  32'(iss_rob),  e.rob);
        chk("sb_op1",  32'(iss_op1),  e.op1);
        chk("sb_op2",  32'(iss_op2),  e.op2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_func = '0; disp_rob = '0;
    disp_v1 = '0; disp_v2 = '0; disp_q1 = '0; disp_q2 = '0; disp_p1 = 1'b0; disp_p2 = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; iss_ready = 1'b1;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_iss_op1",   32'(iss_op1), 0);
    chk("rst_iss_rob",   32'(iss_rob), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_disp_ready", 32'(disp_ready), 1);

    // Simple ready instruction: valid two edges after dispatch
    disp(0, 1, 5, 7, 0, 0, 0, 0); expect_iss(0, 1, 5, 7);
    tick(); disp_valid = 1'b0;
    chk("t1_not_yet", 32'(iss_valid), 0);
    chk("t1_occ1",    32'(occupancy), 1);
    tick();
    chk("t1_iss_valid", 32'(iss_valid), 1);
    chk("t1_op1", 32'(iss_op1), 5);
    chk("t1_op2", 32'(iss_op2), 7);
    chk("t1_rob", 32'(iss_rob), 1);
    chk("t1_occ0", 32'(occupancy), 0);
    tick();
    chk("t1_drop", 32'(iss_valid), 0);

    // Pending operand woken by CDB three cycles later
    disp(1, 2, 0, 'h11, 1, 3, 0, 0);
    tick(); disp_valid = 1'b0;
    tick(); tick();
    chk("t2_wait", 32'(iss_valid), 0);
    cdb(3, 'h00AA); expect_iss(1, 2, 'h00AA, 'h11);
    tick(); cdb_valid = 1'b0;
    chk("t2_no_same_cycle", 32'(iss_valid), 0);
    tick();
    chk("t2_iss_valid", 32'(iss_valid), 1);
    chk("t2_op1", 32'(iss_op1), 'h00AA);
    tick();

    // Fill all slots with pending ops; rob0 waits on 4, rob1/rob3 on 5, rob2 on 6
    for (int i = 0; i < 4; i++) begin
      disp(i, i, 0, 'h100 + i, 1, (i == 0) ? 4 : (i == 2) ? 6 : 5, 0, 0);
      tick();
    end
    disp_valid = 1'b0;
    chk("t3_full_ready", 32'(disp_ready), 0);
    chk("t3_full_occ",   32'(occupancy), 4);
    disp(9, 5, 1, 2, 0, 0, 0, 0);
    tick(); disp_valid = 1'b0;
    chk("t3_ignored_occ", 32'(occupancy), 4);
    chk("t3_ignored_iss", 32'(iss_valid), 0);
    cdb(6, 'h66); expect_iss(2, 2, 'h66, 'h102);
    tick();
    cdb(4, 'h44); expect_iss(0, 0, 'h44, 'h100);
    tick(); cdb_valid = 1'b0;
    chk("t3_first_rob2", 32'(iss_rob), 2);
    tick();
    chk("t3_then_rob0", 32'(iss_rob), 0);
    chk("t3_occ2", 32'(occupancy), 2);
    tick();
    chk("t3_idle", 32'(iss_valid), 0);
    chk("t3_ready_again", 32'(disp_ready), 1);
    // rob4 reuses slot 0 but is youngest; one broadcast wakes three slots
    disp(4, 4, 0, 'h104, 1, 5, 0, 0);
    tick(); disp_valid = 1'b0;
    chk("t3_occ3", 32'(occupancy), 3);
    cdb(5, 'h55);
    expect_iss(1, 1, 'h55, 'h101); expect_iss(3, 3, 'h55, 'h103); expect_iss(4, 4, 'h55, 'h104);
    tick(); cdb_valid = 1'b0;
    tick(); chk("t3_age_rob1", 32'(iss_rob), 1);
    tick(); chk("t3_age_rob3", 32'(iss_rob), 3);
    tick(); chk("t3_age_rob4", 32'(iss_rob), 4);
    tick();
    chk("t3_empty_valid", 32'(iss_valid), 0);
    chk("t3_empty_occ", 32'(occupancy), 0);

    // Backpressure: hold for 5 cycles with two ready slots
    iss_ready = 1'b0;
    disp(5, 5, 1, 2, 0, 0, 0, 0); expect_iss(5, 5, 1, 2);
    tick();
    disp(6, 6, 3, 4, 0, 0, 0, 0); expect_iss(6, 6, 3, 4);
    tick(); disp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(iss_valid), 1);
      chk("t4_hold_rob",   32'(iss_rob), 5);
      chk("t4_hold_op1",   32'(iss_op1), 1);
      chk("t4_hold_occ",   32'(occupancy), 1);
      tick();
    end
    iss_ready = 1'b1;
    tick();
    chk("t4_next_rob", 32'(iss_rob), 6);
    chk("t4_next_op2", 32'(iss_op2), 4);
    tick();
    chk("t4_drain", 32'(iss_valid), 0);

    // Operand captured from the CDB in the dispatch cycle
    disp(7, 7, 'h33, 0, 0, 0, 1, 4); cdb(4, 9); expect_iss(7, 7, 'h33, 9);
    tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    chk("t5_iss_valid", 32'(iss_valid), 1);
    chk("t5_op2", 32'(iss_op2), 9);
    tick();

    // Flush with three valid slots and a held issue, plus a competing dispatch
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(i, i, i + 1, i + 2, 0, 0, 0, 0);
      tick();
    end
    disp_valid = 1'b0;
    chk("t6_pre_occ", 32'(occupancy), 3);
    chk("t6_pre_iss", 32'(iss_valid), 1);
    flush = 1'b1; disp(2, 2, 0, 0, 0, 0, 0, 0);
    tick(); flush = 1'b0; disp_valid = 1'b0;
    chk("t6_flush_iss", 32'(iss_valid), 0);
    chk("t6_flush_occ", 32'(occupancy), 0);
    chk("t6_flush_ready", 32'(disp_ready), 1);
    iss_ready = 1'b1;
    tick(); tick();
    chk("t6_nothing_left", 32'(iss_valid), 0);

    // Asynchronous reset in the middle of a stall
    iss_ready = 1'b0;
    disp(3, 1, 'hA, 'hB, 0, 0, 0, 0);
    tick(); disp_valid = 1'b0;
    tick();
    chk("t7_stalled", 32'(iss_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_iss", 32'(iss_valid), 0);
    chk("t7_async_op1", 32'(iss_op1), 0);
    chk("t7_async_occ", 32'(occupancy), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("t7_ready_after", 32'(disp_ready), 1);
    iss_ready = 1'b1;
    disp(2, 3, 'h1234, 'h4321, 0, 0, 0, 0); expect_iss(2, 3, 'h1234, 'h4321);
    tick(); disp_valid = 1'b0;
    tick();
    chk("t7_post_reset_issue", 32'(iss_valid), 1);
    tick(); tick();

    chk("sb_empty", 32'(sb.size()), 0);
    chk("issue_count", 32'(n_popped), 32'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
